// File: rtl/serial_operand_sequencer_if.sv
// Handshake and data bundle between the controller, the bit-serial ALU and the
// serial operand sequencer.
interface serial_operand_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       op_in;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             alu_out;
    logic             ina;
    logic             inb;
    logic [2:0]       op;
    logic             alu_first;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op_in, opa, opb, alu_out,
        input  ina, inb, op, alu_first, busy, done, result
    );

    modport slave (
        input  start, op_in, opa, opb, alu_out,
        output ina, inb, op, alu_first, busy, done, result
    );
endinterface

// File: rtl/serial_operand_sequencer.sv
// Bit-serial front/back end: feeds operand bit pairs LSB first to the serial ALU
// and reassembles its serial result into a parallel word.
//
//   state | meaning
//   IDLE  | waiting for start; result and op hold
//   SHIFT | presenting bit pair idx, sampling alu_out at the end of the cycle
//   DONE  | one-cycle done pulse, result final
module serial_operand_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input logic                      clk,
    input logic                      rst,
    serial_operand_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] idx, idx_nxt;
    logic [WIDTH-1:0] sa, sa_nxt;
    logic [WIDTH-1:0] sb, sb_nxt;
    logic [WIDTH-1:0] res, res_nxt;
    logic [2:0]       op_q, op_nxt;
    logic             ina_q, ina_nxt;
    logic             inb_q, inb_nxt;
    logic             first_q, first_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            sa      <= '0;
            sb      <= '0;
            res     <= '0;
            op_q    <= '0;
            ina_q   <= 1'b0;
            inb_q   <= 1'b0;
            first_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            sa      <= sa_nxt;
            sb      <= sb_nxt;
            res     <= res_nxt;
            op_q    <= op_nxt;
            ina_q   <= ina_nxt;
            inb_q   <= inb_nxt;
            first_q <= first_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        sa_nxt    = sa;
        sb_nxt    = sb;
        res_nxt   = res;
        op_nxt    = op_q;
        ina_nxt   = 1'b0;
        inb_nxt   = 1'b0;
        first_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    // Bit 0 goes out on the accepting edge; the shift regs keep the rest.
                    sa_nxt    = bus.opa >> 1;
                    sb_nxt    = bus.opb >> 1;
                    op_nxt    = bus.op_in;
                    idx_nxt   = '0;
                    ina_nxt   = bus.opa[0];
                    inb_nxt   = bus.opb[0];
                    first_nxt = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                res_nxt = {bus.alu_out, res[WIDTH-1:1]};
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + CNT_W'(1);
                    ina_nxt = sa[0];
                    inb_nxt = sb[0];
                    sa_nxt  = sa >> 1;
                    sb_nxt  = sb >> 1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
    end

    assign bus.ina       = ina_q;
    assign bus.inb       = inb_q;
    assign bus.op        = op_q;
    assign bus.alu_first = first_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = res;

endmodule

// File: tb/tb_serial_operand_sequencer.sv
// Scoreboard bench for serial_operand_sequencer with a serial-adder ALU model;
// a 16-bit and a 4-bit instance share clock and reset.
module tb_serial_operand_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_operand_sequencer_if #(.WIDTH(16)) b16();
    serial_operand_sequencer_if #(.WIDTH(4))  b4();

    serial_operand_sequencer #(.WIDTH(16), .CNT_W(4)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    serial_operand_sequencer #(.WIDTH(4),  .CNT_W(2)) dut4  (.clk(clk), .rst(rst), .bus(b4));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Serial adder ALU models; carry is ignored while alu_first is high.
    logic carry16 = 1'b0, carry4 = 1'b0;
    logic cin16, cin4;
    assign cin16 = b16.alu_first ? 1'b0 : carry16;
    assign cin4  = b4.alu_first  ? 1'b0 : carry4;
    assign b16.alu_out = b16.ina ^ b16.inb ^ cin16;
    assign b4.alu_out  = b4.ina  ^ b4.inb  ^ cin4;
    always @(posedge clk) begin
        carry16 <= (b16.ina & b16.inb) | (b16.ina & cin16) | (b16.inb & cin16);
        carry4  <= (b4.ina & b4.inb) | (b4.ina & cin4) | (b4.inb & cin4);
    end

    typedef struct {
        logic [15:0] res;
        logic [2:0]  op;
    } exp16_t;
    exp16_t     q16[$];
    logic [3:0] q4[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (b16.done === 1'b1) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done16: got done=1 expected no pending operation (t=%0t)", $time);
            end else begin
                exp16_t e;
                e = q16.pop_front();
                check("result16", 32'(b16.result), 32'(e.res));
                check("op16_in_done", 32'(b16.op), 32'(e.op));
                check("busy16_in_done", 32'(b16.busy), 32'd1);
            end
        end
    end

    int last4 = -1;
    always @(negedge clk) begin
        if (b4.done === 1'b1) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done4: got done=1 expected no pending operation (t=%0t)", $time);
            end else begin
                logic [3:0] e4;
                e4 = q4.pop_front();
                check("result4", 32'(b4.result), 32'(e4));
            end
            if (last4 >= 0) check("period4", 32'(cyc - last4), 32'd6);
            last4 = cyc;
        end
    end

    task automatic wait_done16();
        int n;
        n = 0;
        while (b16.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL done16_timeout: got no done within 40 cycles expected done");
        end
        @(negedge clk);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] o, input logic [15:0] exp_res);
        @(negedge clk);
        b16.start = 1'b1;
        b16.opa   = a;
        b16.opb   = b;
        b16.op_in = o;
        q16.push_back('{exp_res, o});
        @(posedge clk);
        #1 b16.start = 1'b0;
        wait_done16();
    endtask

    task automatic check_reset16(input string tag);
        check({tag, "_busy"},  32'(b16.busy),      32'd0);
        check({tag, "_done"},  32'(b16.done),      32'd0);
        check({tag, "_result"},32'(b16.result),    32'd0);
        check({tag, "_ina"},   32'(b16.ina),       32'd0);
        check({tag, "_inb"},   32'(b16.inb),       32'd0);
        check({tag, "_op"},    32'(b16.op),        32'd0);
        check({tag, "_first"}, 32'(b16.alu_first), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200us");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ea, eb;
        rst = 1'b1;
        b16.start = 1'b1; b16.opa = 16'hA5A5; b16.opb = 16'h0F0F; b16.op_in = 3'd5;
        b4.start  = 1'b0; b4.opa  = 4'h0;     b4.opb  = 4'h0;     b4.op_in  = 3'd0;

        // Reset held with start high: nothing may begin.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset16("reset");
        check("reset_busy4", 32'(b4.busy), 32'd0);

        // Bit order; start is still high so the first edge after rst drops accepts.
        rst = 1'b0;
        q16.push_back('{16'hB4B4, 3'd5});
        @(posedge clk);
        #1;
        b16.start = 1'b0;
        b16.opa = 16'hFFFF; b16.opb = 16'hFFFF; b16.op_in = 3'd7;
        ea = 16'hA5A5;
        eb = 16'h0F0F;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check($sformatf("ina_bit%0d", k),   32'(b16.ina),       32'(ea[k]));
            check($sformatf("inb_bit%0d", k),   32'(b16.inb),       32'(eb[k]));
            check($sformatf("first_bit%0d", k), 32'(b16.alu_first), (k == 0) ? 32'd1 : 32'd0);
            check($sformatf("busy_bit%0d", k),  32'(b16.busy),      32'd1);
            check($sformatf("done_bit%0d", k),  32'(b16.done),      32'd0);
        end
        @(negedge clk);
        check("done_latency17", 32'(b16.done), 32'd1);
        check("ina_in_done", 32'(b16.ina), 32'd0);
        @(negedge clk);
        check("idle_busy", 32'(b16.busy), 32'd0);
        check("idle_done", 32'(b16.done), 32'd0);
        check("idle_result_hold", 32'(b16.result), 32'hB4B4);
        check("idle_op_hold", 32'(b16.op), 32'd5);

        // Reassembly.
        run16(16'h0003, 16'h0005, 3'b000, 16'h0008);
        run16(16'hFFFF, 16'h0001, 3'b000, 16'h0000);

        // Start while busy at index 7 is ignored.
        @(negedge clk);
        b16.start = 1'b1; b16.opa = 16'h1234; b16.opb = 16'h1111; b16.op_in = 3'd2;
        q16.push_back('{16'h2345, 3'd2});
        @(posedge clk);
        #1 b16.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        b16.start = 1'b1; b16.opa = 16'h0F00; b16.opb = 16'h00F0; b16.op_in = 3'd7;
        @(posedge clk);
        #1 b16.start = 1'b0;
        check("op_held_after_ignored_start", 32'(b16.op), 32'd2);
        wait_done16();
        repeat (25) @(negedge clk);
        check("busy_after_ignored_start", 32'(b16.busy), 32'd0);

        // Reset at index 8 aborts with no done pulse.
        @(negedge clk);
        b16.start = 1'b1; b16.opa = 16'hAAAA; b16.opb = 16'h5555; b16.op_in = 3'd6;
        @(posedge clk);
        #1 b16.start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_reset16("midrst");
        repeat (25) @(negedge clk);
        check("midrst_busy_later", 32'(b16.busy), 32'd0);
        run16(16'h0003, 16'h0005, 3'b000, 16'h0008);

        // Back-to-back on the 4-bit instance with start held.
        @(negedge clk);
        b4.start = 1'b1; b4.opa = 4'h3; b4.opb = 4'h4; b4.op_in = 3'd1;
        q4.push_back(4'h7);
        q4.push_back(4'h8);
        @(posedge clk);
        #1 b4.opa = 4'h7; b4.opb = 4'h1;
        repeat (6) @(posedge clk);
        #1 b4.start = 1'b0;
        check("b2b_second_accepted", 32'(b4.busy), 32'd1);
        repeat (14) @(negedge clk);
        check("b2b_idle", 32'(b4.busy), 32'd0);

        check("pending16", 32'(q16.size()), 32'd0);
        check("pending4",  32'(q4.size()),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
